// File: rtl/hd44780_pkg.sv
// Shared command codes, top FSM state type and default 27 MHz cycle counts
// for the HD44780 write-only driver.
package hd44780_pkg;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_OFF = 8'h08;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_FSET8    = 8'h38;
    localparam logic [7:0] CMD_FSET4    = 8'h28;
    localparam logic [3:0] WAKE_NIB     = 4'h3;

    // Single-nibble init writes ride on the upper nibble of a byte.
    localparam logic [7:0] WAKE_BYTE = {WAKE_NIB, 4'h0};
    localparam logic [7:0] NIB2_BYTE = {CMD_FSET4[7:4], 4'h0};

    localparam int unsigned DEF_T_SU       = 2;
    localparam int unsigned DEF_T_PW       = 13;
    localparam int unsigned DEF_T_H        = 14;
    localparam int unsigned DEF_T_EXEC     = 1080;
    localparam int unsigned DEF_T_CLR      = 44280;
    localparam int unsigned DEF_T_INIT_GAP = 110700;
    localparam int unsigned DEF_T_PWR      = 1080000;

    typedef enum logic [2:0] {
        StPwrWait,
        StWake,
        StNib2,
        StInitCmds,
        StIdle,
        StXfer,
        StWait
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] idx, input logic four);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = four ? CMD_FSET4 : CMD_FSET8;
            3'd1:    cmd = CMD_DISP_OFF;
            3'd2:    cmd = CMD_CLEAR;
            3'd3:    cmd = CMD_ENTRY;
            default: cmd = CMD_DISP_ON;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/hd44780_strobe.sv
// One E-pulse generator: drives rs/db, waits T_SU, holds e for T_PW, then T_H low.
// A start seen on the last hold cycle chains the next strobe with no gap.
module hd44780_strobe
    import hd44780_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned T_SU      = DEF_T_SU,
    parameter int unsigned T_PW      = DEF_T_PW,
    parameter int unsigned T_H       = DEF_T_H
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rs_sel,
    input  logic [BUS_WIDTH-1:0] nib_or_byte,
    output logic                 done,
    output logic                 e,
    output logic                 rs,
    output logic [BUS_WIDTH-1:0] db
);

    localparam int unsigned CW = cnt_width(T_SU, T_PW, T_H, 1);

    typedef enum logic [1:0] {PhIdle, PhSu, PhPw, PhHold} phase_t;

    phase_t        phase_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [CW-1:0] ld(input int unsigned n);
        return CW'(n - 1);
    endfunction

    assign done = (phase_q == PhHold) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PhIdle;
            cnt_q   <= '0;
            e       <= 1'b0;
            rs      <= 1'b0;
            db      <= '0;
        end else begin
            unique case (phase_q)
                PhIdle: begin
                    if (start) begin
                        rs      <= rs_sel;
                        db      <= nib_or_byte;
                        cnt_q   <= ld(T_SU);
                        phase_q <= PhSu;
                    end
                end
                PhSu: begin
                    if (cnt_q == '0) begin
                        e       <= 1'b1;
                        cnt_q   <= ld(T_PW);
                        phase_q <= PhPw;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PhPw: begin
                    if (cnt_q == '0) begin
                        e       <= 1'b0;
                        cnt_q   <= ld(T_H);
                        phase_q <= PhHold;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PhHold: begin
                    if (cnt_q == '0) begin
                        if (start) begin
                            rs      <= rs_sel;
                            db      <= nib_or_byte;
                            cnt_q   <= ld(T_SU);
                            phase_q <= PhSu;
                        end else begin
                            phase_q <= PhIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: phase_q <= PhIdle;
            endcase
        end
    end

endmodule

// File: rtl/hd44780_writer.sv
// Write-only HD44780 driver: power-on init, then command/data bytes via valid/ready,
// on an 8-bit or 4-bit bus with cycle-counted E timing.
module hd44780_writer
    import hd44780_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned INIT_EN    = 1,
    parameter int unsigned T_SU       = DEF_T_SU,
    parameter int unsigned T_PW       = DEF_T_PW,
    parameter int unsigned T_H        = DEF_T_H,
    parameter int unsigned T_EXEC     = DEF_T_EXEC,
    parameter int unsigned T_CLR      = DEF_T_CLR,
    parameter int unsigned T_INIT_GAP = DEF_T_INIT_GAP,
    parameter int unsigned T_PWR      = DEF_T_PWR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_rs,
    input  logic [7:0]           in_data,
    output logic                 init_done,
    output logic                 e,
    output logic                 rs,
    output logic                 rw,
    output logic [BUS_WIDTH-1:0] db
);

    localparam bit          FOUR = (BUS_WIDTH == 4);
    localparam int unsigned CW   = cnt_width(T_PWR, T_INIT_GAP, T_CLR, T_EXEC);

    state_t         state_q;
    state_t         ret_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     step_q;
    logic [7:0]     byte_q;
    logic           rs_q;
    logic           go_q;
    logic           pend_q;
    logic           stb_done;
    logic           stb_start;
    logic           long_wait;
    logic [3:0]     nib;
    logic [BUS_WIDTH-1:0] stb_data;

    function automatic logic [CW-1:0] ld(input int unsigned n);
        return CW'(n - 1);
    endfunction

    // pend_q marks a pending low nibble; it is chained on the first nibble's last hold cycle.
    assign stb_start = go_q | (stb_done & pend_q);
    assign nib       = (stb_done && pend_q) ? byte_q[3:0] : byte_q[7:4];
    assign stb_data  = (BUS_WIDTH == 8) ? BUS_WIDTH'(byte_q) : BUS_WIDTH'(nib);
    assign long_wait = !rs_q && (byte_q == CMD_CLEAR || byte_q == CMD_HOME || byte_q == 8'h03);
    assign rw        = 1'b0;

    hd44780_strobe #(
        .BUS_WIDTH (BUS_WIDTH),
        .T_SU      (T_SU),
        .T_PW      (T_PW),
        .T_H       (T_H)
    ) u_strobe (
        .clk         (clk),
        .rst         (rst),
        .start       (stb_start),
        .rs_sel      (rs_q),
        .nib_or_byte (stb_data),
        .done        (stb_done),
        .e           (e),
        .rs          (rs),
        .db          (db)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StPwrWait;
            ret_q     <= StPwrWait;
            cnt_q     <= ld(T_PWR);
            step_q    <= '0;
            byte_q    <= '0;
            rs_q      <= 1'b0;
            go_q      <= 1'b0;
            pend_q    <= 1'b0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            go_q <= 1'b0;
            unique case (state_q)
                StPwrWait: begin
                    if (INIT_EN == 0) begin
                        state_q   <= StIdle;
                        in_ready  <= 1'b1;
                        init_done <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= StWake;
                        byte_q  <= WAKE_BYTE;
                        go_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StWake: begin
                    if (stb_done) begin
                        state_q <= StWait;
                        cnt_q   <= ld(T_INIT_GAP);
                        if (step_q == 3'd2) begin
                            step_q <= '0;
                            ret_q  <= FOUR ? StNib2 : StInitCmds;
                        end else begin
                            step_q <= step_q + 1'b1;
                            ret_q  <= StWake;
                        end
                    end
                end
                StNib2: begin
                    if (stb_done) begin
                        state_q <= StWait;
                        cnt_q   <= ld(T_EXEC);
                        ret_q   <= StInitCmds;
                    end
                end
                StInitCmds: begin
                    if (stb_done) begin
                        if (pend_q) begin
                            pend_q <= 1'b0;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= long_wait ? ld(T_CLR) : ld(T_EXEC);
                            if (step_q == 3'd4) begin
                                ret_q <= StIdle;
                            end else begin
                                ret_q  <= StInitCmds;
                                step_q <= step_q + 1'b1;
                            end
                        end
                    end
                end
                StIdle: begin
                    if (in_valid) begin
                        byte_q   <= in_data;
                        rs_q     <= in_rs;
                        in_ready <= 1'b0;
                        go_q     <= 1'b1;
                        pend_q   <= FOUR;
                        state_q  <= StXfer;
                    end
                end
                StXfer: begin
                    if (stb_done) begin
                        if (pend_q) begin
                            pend_q <= 1'b0;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= long_wait ? ld(T_CLR) : ld(T_EXEC);
                            ret_q   <= StIdle;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= ret_q;
                        unique case (ret_q)
                            StWake: go_q <= 1'b1;
                            StNib2: begin
                                byte_q <= NIB2_BYTE;
                                go_q   <= 1'b1;
                            end
                            StInitCmds: begin
                                byte_q <= init_cmd(step_q, FOUR);
                                go_q   <= 1'b1;
                                pend_q <= FOUR;
                            end
                            default: begin
                                in_ready  <= 1'b1;
                                init_done <= 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StPwrWait;
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_writer.sv
// Directed bench for hd44780_writer: 8-bit init, 4-bit init and write,
// 8-bit write without init, back-to-back accept and asynchronous reset mid-pulse.
module tb_hd44780_writer;

    localparam int unsigned TSU = 2, TPW = 3, TH = 4, TEXEC = 10, TCLR = 20, TGAP = 30;
    localparam int unsigned TPWR = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, val_a, rdy_a, rsi_a, idn_a, e_a, rs_a, rw_a;
    logic [7:0] din_a, db_a;
    logic       rst_b, val_b, rdy_b, rsi_b, idn_b, e_b, rs_b, rw_b;
    logic [7:0] din_b;
    logic [3:0] db_b;
    logic       rst_c, val_c, rdy_c, rsi_c, idn_c, e_c, rs_c, rw_c;
    logic [7:0] din_c, db_c;

    hd44780_writer #(.BUS_WIDTH(8), .INIT_EN(1), .T_SU(TSU), .T_PW(TPW), .T_H(TH),
        .T_EXEC(TEXEC), .T_CLR(TCLR), .T_INIT_GAP(TGAP), .T_PWR(TPWR)) u_a (
        .clk(clk), .rst(rst_a), .in_valid(val_a), .in_ready(rdy_a), .in_rs(rsi_a),
        .in_data(din_a), .init_done(idn_a), .e(e_a), .rs(rs_a), .rw(rw_a), .db(db_a));

    hd44780_writer #(.BUS_WIDTH(4), .INIT_EN(1), .T_SU(TSU), .T_PW(TPW), .T_H(TH),
        .T_EXEC(TEXEC), .T_CLR(TCLR), .T_INIT_GAP(TGAP), .T_PWR(TPWR)) u_b (
        .clk(clk), .rst(rst_b), .in_valid(val_b), .in_ready(rdy_b), .in_rs(rsi_b),
        .in_data(din_b), .init_done(idn_b), .e(e_b), .rs(rs_b), .rw(rw_b), .db(db_b));

    hd44780_writer #(.BUS_WIDTH(8), .INIT_EN(0), .T_SU(TSU), .T_PW(TPW), .T_H(TH),
        .T_EXEC(TEXEC), .T_CLR(TCLR), .T_INIT_GAP(TGAP), .T_PWR(TPWR)) u_c (
        .clk(clk), .rst(rst_c), .in_valid(val_c), .in_ready(rdy_c), .in_rs(rsi_c),
        .in_data(din_c), .init_done(idn_c), .e(e_c), .rs(rs_c), .rw(rw_c), .db(db_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus log: value of db (and init_done) captured on every e rise.
    logic [7:0]  log_a[$];
    int unsigned rise_a[$];
    logic        dn_a[$];
    logic [3:0]  log_b[$];
    logic [7:0]  log_c[$];
    logic        pe_a = 1'b0, pe_b = 1'b0, pe_c = 1'b0;
    int          rw_bad = 0;

    always @(negedge clk) begin
        if (e_a && !pe_a) begin
            log_a.push_back(db_a);
            rise_a.push_back(cyc);
            dn_a.push_back(idn_a);
        end
        if (e_b && !pe_b) log_b.push_back(db_b);
        if (e_c && !pe_c) log_c.push_back(db_c);
        pe_a <= e_a;
        pe_b <= e_b;
        pe_c <= e_c;
        if (rw_a || rw_b || rw_c) rw_bad <= rw_bad + 1;
    end

    logic [7:0] exp8[8]  = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    logic [3:0] exp4[14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8,
                             4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned rel, done_cyc;
        int ret, ehi, efirst, stab_bad, nb;

        rst_a = 1; rst_b = 1; rst_c = 1;
        val_a = 0; val_b = 0; val_c = 0;
        rsi_a = 0; rsi_b = 0; rsi_c = 0;
        din_a = 0; din_b = 0; din_c = 0;
        repeat (3) @(negedge clk);
        check("a_reset", 32'({e_a, rs_a, rw_a, db_a, rdy_a, idn_a}), 32'h0);
        check("b_reset", 32'({e_b, rs_b, rw_b, db_b, rdy_b, idn_b}), 32'h0);
        check("c_reset", 32'({e_c, rs_c, rw_c, db_c, rdy_c, idn_c}), 32'h0);

        // 8-bit init sequence
        rel = cyc;
        rst_a = 0;
        for (int i = 0; i < 3000 && !idn_a; i++) @(negedge clk);
        done_cyc = cyc;
        check("a_init_done", 32'(idn_a), 32'h1);
        check("a_pulse_count", 32'(log_a.size()), 32'd8);
        if (log_a.size() == 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("a_init_db%0d", i), 32'(log_a[i]), 32'(exp8[i]));
            check("a_first_e_ge_50", 32'(rise_a[0] - rel >= 50), 32'h1);
            check("a_done_low_at_last", 32'(dn_a[7]), 32'h0);
            check("a_done_after_wait", done_cyc - rise_a[7], TPW + TH + TEXEC);
        end
        check("a_ready_after_init", 32'(rdy_a), 32'h1);

        // 4-bit init sequence
        rst_b = 0;
        for (int i = 0; i < 3000 && !idn_b; i++) @(negedge clk);
        check("b_init_done", 32'(idn_b), 32'h1);
        check("b_nib_count", 32'(log_b.size()), 32'd14);
        if (log_b.size() == 14)
            for (int i = 0; i < 14; i++)
                check($sformatf("b_init_nib%0d", i), 32'(log_b[i]), 32'(exp4[i]));

        // 4-bit clear write with valid held throughout
        nb = log_b.size();
        val_b = 1; rsi_b = 0; din_b = 8'h01;
        @(negedge clk);
        check("b_accept_ready_low", 32'(rdy_b), 32'h0);
        ret = -1;
        for (int j = 1; j <= 60 && ret < 0; j++) begin
            @(negedge clk);
            if (rdy_b) ret = j;
        end
        check("b_ready_return", 32'(ret), 32'd39);
        check("b_xfer_nibs", 32'(log_b.size() - nb), 32'd2);
        if (log_b.size() == nb + 2) begin
            check("b_hi_nib", 32'(log_b[nb]), 32'h0);
            check("b_lo_nib", 32'(log_b[nb+1]), 32'h1);
        end
        @(negedge clk);
        check("b_held_valid_accept", 32'(rdy_b), 32'h0);
        val_b = 0;
        for (int i = 0; i < 100 && !rdy_b; i++) @(negedge clk);
        check("b_second_xfer_nibs", 32'(log_b.size() - nb), 32'd4);

        // 8-bit, no init: ready one cycle after release, then a data write
        rst_c = 0;
        @(negedge clk);
        check("c_noinit_done", 32'({idn_c, rdy_c}), 32'h3);
        val_c = 1; rsi_c = 1; din_c = 8'h41;
        @(negedge clk);
        check("c_accept_ready_low", 32'(rdy_c), 32'h0);
        val_c = 0; din_c = 8'h00; rsi_c = 0;
        ret = -1; ehi = 0; efirst = -1; stab_bad = 0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (e_c) begin
                ehi++;
                if (efirst < 0) efirst = j;
            end
            if (j <= 19 && (db_c !== 8'h41 || rs_c !== 1'b1)) stab_bad++;
            if (rdy_c && ret < 0) ret = j;
        end
        check("c_e_high_cycles", 32'(ehi), 32'd3);
        check("c_e_rise_offset", 32'(efirst), 32'd3);
        check("c_db_rs_stable", 32'(stab_bad), 32'd0);
        check("c_ready_return", 32'(ret), 32'd20);

        // Clear command followed by a held back-to-back data byte
        val_c = 1; rsi_c = 0; din_c = 8'h01;
        @(negedge clk);
        rsi_c = 1; din_c = 8'h55;
        ret = -1;
        for (int j = 1; j <= 60 && ret < 0; j++) begin
            @(negedge clk);
            if (rdy_c) ret = j;
        end
        check("c_clr_ready_return", 32'(ret), 32'd30);
        @(negedge clk);
        check("c_b2b_accept", 32'(rdy_c), 32'h0);
        val_c = 0;
        for (int i = 0; i < 100 && !rdy_c; i++) @(negedge clk);
        check("c_log_count", 32'(log_c.size()), 32'd3);
        if (log_c.size() == 3)
            check("c_log_bytes", 32'({log_c[0], log_c[1], log_c[2]}), 32'h410155);

        // Asynchronous reset during the e-high phase, then full init restart
        val_a = 1; rsi_a = 1; din_a = 8'h41;
        @(negedge clk);
        val_a = 0;
        for (int i = 0; i < 20 && !e_a; i++) @(negedge clk);
        check("a_e_high_before_rst", 32'(e_a), 32'h1);
        #2 rst_a = 1;
        #1 check("a_async_rst", 32'({e_a, rs_a, db_a, rdy_a, idn_a}), 32'h0);
        @(negedge clk);
        log_a.delete();
        rise_a.delete();
        dn_a.delete();
        rel = cyc;
        rst_a = 0;
        for (int i = 0; i < 3000 && !idn_a; i++) @(negedge clk);
        check("a_reinit_done", 32'(idn_a), 32'h1);
        check("a_reinit_count", 32'(log_a.size()), 32'd8);
        if (log_a.size() == 8) begin
            check("a_reinit_first", 32'(log_a[0]), 32'h30);
            check("a_reinit_last", 32'(log_a[7]), 32'h0C);
            check("a_reinit_first_e_ge_50", 32'(rise_a[0] - rel >= 50), 32'h1);
        end

        check("rw_always_zero", 32'(rw_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hd44780_writer.md
# hd44780_writer

Parametrised, write-only HD44780 character-LCD driver for the board top level. It replaces free-running divided clocks on `e`/`rs`/`rw`/`db` with cycle-counted bus timing on the system clock. It runs the datasheet power-on initialisation and then accepts command/data bytes through a valid/ready handshake. It supports 8-bit and 4-bit bus modes.

## Interface
Parameters:
- `BUS_WIDTH`, 8: LCD data bus width; legal values 8 or 4.
- `INIT_EN`, 1: when 1, run the power-on init sequence after reset; when 0, start directly in IDLE.
- `T_SU`, 2: cycles that `rs`/`db` are stable before `e` rises (≥60 ns at 27 MHz).
- `T_PW`, 13: cycles `e` is high (≥450 ns).
- `T_H`, 14: cycles `e` is low after a pulse before the next bus change (E cycle ≥1000 ns).
- `T_EXEC`, 1080: post-write wait for ordinary commands and data (40 µs).
- `T_CLR`, 44280: post-write wait for clear/home (1.64 ms).
- `T_INIT_GAP`, 110700: wait after each wake-up write (4.1 ms).
- `T_PWR`, 1080000: power-on wait before the first init write (40 ms).

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `in_rs` in 1: 0 = command, 1 = data.
- `in_data` in 8: byte to write.
- `init_done` out 1: init sequence complete; sticky until reset.
- `e` out 1: LCD enable.
- `rs` out 1: LCD register select.
- `rw` out 1: LCD read/write. Constant 0; the block is write-only.
- `db` out `BUS_WIDTH`: LCD data bus. In 4-bit mode, `db[3:0]` carries D7..D4.

## Operation
- Reset values: `e`=0, `rs`=0, `rw`=0, `db`=0, `in_ready`=0, `init_done`=0.
- All outputs are registered.
- Asserting `rst` mid-transfer forces the reset values immediately. Init restarts on release.
- Top FSM states: PWR_WAIT → WAKE(×3) → [4-bit: NIB2] → INIT_CMDS → IDLE → XFER → WAIT → IDLE.
- PWR_WAIT: count `T_PWR` cycles.
- WAKE: single strobe of 0x3 on the upper nibble (0x30 on an 8-bit bus), rs=0. Followed by a `T_INIT_GAP` wait. Repeated 3 times.
- NIB2 (4-bit only): single nibble strobe of 0x2, then `T_EXEC`.
- INIT_CMDS: full command writes, in order:
  - function set: 0x38 (8-bit) or 0x28 (4-bit)
  - 0x08
  - 0x01 (followed by `T_CLR`)
  - 0x06
  - 0x0C
- After the last init command and its wait, `init_done` rises and the FSM enters IDLE.
- With `INIT_EN`=0, the FSM goes directly to IDLE and `init_done`=1 one cycle after reset release.
- IDLE: `in_ready`=1.
- Accept rule: a request is accepted on a rising edge where `in_valid && in_ready`. `in_rs`/`in_data` are latched on that edge. `in_ready` falls on that same edge.
- `in_valid` while `in_ready`=0 (during init or a transfer) is ignored; nothing is queued.
- XFER:
  - 8-bit: one strobe with the full byte.
  - 4-bit: strobe of the high nibble, then strobe of the low nibble. `rs` is held across both strobes.
- Strobe sequence: drive `rs`/`db`, then `T_SU` cycles with `e`=0, then `T_PW` cycles with `e`=1, then `T_H` cycles with `e`=0.
- `db` and `rs` hold their value until the next strobe. They never change while `e`=1.
- WAIT length: `T_CLR` when `in_rs`=0 and `in_data` ∈ {0x01,0x02,0x03}; otherwise `T_EXEC`.
- Counters: a single down-counter, sized `$clog2` of the largest parameter plus 1. It is loaded with N−1 and terminates at 0.

## Timing
- Accept on edge k: `rs`/`db` are valid after edge k+1. `e` rises at edge k+1+`T_SU`. `e` falls at k+1+`T_SU`+`T_PW`.
- 8-bit, accept to `in_ready` re-high: 1+`T_SU`+`T_PW`+`T_H`+wait cycles.
- 4-bit, accept to `in_ready` re-high: 1+2·(`T_SU`+`T_PW`+`T_H`)+wait cycles.
- Back-to-back: a request held valid is accepted on the first cycle `in_ready`=1. No bubble is inserted beyond that.

## Structure
- `hd44780_pkg` holds:
  - command constants: `CMD_CLEAR`=0x01, `CMD_HOME`=0x02, `CMD_ENTRY`=0x06, `CMD_DISP_OFF`=0x08, `CMD_DISP_ON`=0x0C, `CMD_FSET8`=0x38, `CMD_FSET4`=0x28, `WAKE_NIB`=0x3
  - the top FSM state enum
  - default 27 MHz cycle counts
- Sub-module `hd44780_strobe`: one-nibble/byte E-pulse generator. Inputs: `start`, `rs`, `nib_or_byte`. Output: `done` pulse. Owns `T_SU`/`T_PW`/`T_H` timing and drives `e`/`rs`/`db`.

## Test plan
All scenarios use `T_SU`=2, `T_PW`=3, `T_H`=4, `T_EXEC`=10, `T_CLR`=20, `T_INIT_GAP`=30, `T_PWR`=50.
- 8-bit, `INIT_EN`=1, reset release → exactly 8 `e` pulses. `db` sequence 0x30,0x30,0x30,0x38,0x08,0x01,0x06,0x0C. First `e` rise ≥50 cycles after release. `init_done` rises after the last wait. `rw` is 0 throughout.
- 4-bit init → nibble sequence 3,3,3,2,2,8,0,8,0,1,0,6,0,C on `db`.
- 8-bit, `INIT_EN`=0, write rs=1 data=0x41 → `e` high for 3 cycles. `db`=0x41 and `rs`=1 stable from 2 cycles before `e` rise until ≥4 cycles after `e` fall. `in_ready` returns 1+2+3+4+10=20 cycles after accept.
- 4-bit write rs=0 data=0x01 → nibbles 0,1. `in_ready` returns 1+18+20=39 cycles after accept. `in_valid` held during the transfer is not accepted until `in_ready`=1.
- Assert `rst` during the `e`-high phase of a write → `e`/`db`/`rs`/`in_ready` go to 0 without waiting for a clock edge. After release, the full init sequence restarts.
